// File: rtl/reg_add_stream_pkg.sv
// reg_add shared types: add/saturate modes and the
// flag vector carried alongside every result.
package reg_add_pkg;

  typedef enum logic [1:0] {
    MODE_UWRAP = 2'b00,
    MODE_SWRAP = 2'b01,
    MODE_USAT  = 2'b10,
    MODE_SSAT  = 2'b11
  } mode_e;

  localparam int FLG_C = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/reg_add_stream_if.sv
// Operand/result stream bundle for reg_add_stream.
// master drives operands and consumes results.
interface reg_add_stream_if
  import reg_add_pkg::*;
#(
  parameter int WIDTH = 30
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic             acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  flags_t           flags;
  flags_t           sticky;
  logic             sticky_clr;

  modport master (
    output in_valid, mode, acc, a, b, acc_clr,
    output out_ready, sticky_clr,
    input  in_ready, out_valid, sum, flags, sticky
  );

  modport slave (
    input  in_valid, mode, acc, a, b, acc_clr,
    input  out_ready, sticky_clr,
    output in_ready, out_valid, sum, flags, sticky
  );

endinterface

// File: rtl/reg_add_core.sv
// Combinational add with wrap/saturate modes.
// Z and N are taken from the post-saturation sum.
module reg_add_core
  import reg_add_pkg::*;
#(
  parameter int WIDTH = 30
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] addend_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] sum_o,
  output flags_t           flags_o
);

  logic [WIDTH:0]   raw;
  logic             c;
  logic             v;
  logic [WIDTH-1:0] max_pos;
  logic [WIDTH-1:0] min_neg;

  assign raw = {1'b0, a_i} + {1'b0, addend_i};
  assign c   = raw[WIDTH];
  assign v   = (a_i[WIDTH-1] == addend_i[WIDTH-1])
            && (raw[WIDTH-1] != a_i[WIDTH-1]);

  assign max_pos = {1'b0, {(WIDTH-1){1'b1}}};
  assign min_neg = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    sum_o = raw[WIDTH-1:0];
    case (mode_i)
      MODE_USAT: if (c) sum_o = '1;
      // on overflow both signs agree, so a's sign picks the rail
      MODE_SSAT: if (v) sum_o = a_i[WIDTH-1] ? min_neg : max_pos;
      default: ;
    endcase
    flags_o        = '0;
    flags_o[FLG_C] = c;
    flags_o[FLG_V] = v;
    flags_o[FLG_Z] = (sum_o == '0);
    flags_o[FLG_N] = sum_o[WIDTH-1];
  end

endmodule

// File: rtl/reg_add_stream.sv
// Streaming adder: accumulator feedback, output register
// plus one-entry skid buffer, sticky flag collection.
module reg_add_stream
  import reg_add_pkg::*;
#(
  parameter int WIDTH     = 30,
  parameter bit STICKY_EN = 1'b1
) (
  input logic              clk,
  input logic              reset,
  reg_add_stream_if.slave  bus
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] res_sum;
  flags_t           res_flg;
  logic             accept;
  logic             deliver;

  logic             rdy_q;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic             ov_q,    ov_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  flags_t           flg_q,   flg_d;
  logic             sk_vq,   sk_vd;
  logic [WIDTH-1:0] sk_sq,   sk_sd;
  flags_t           sk_fq,   sk_fd;

  assign addend  = bus.acc ? acc_q : bus.b;
  assign accept  = bus.in_valid && rdy_q;
  assign deliver = ov_q && bus.out_ready;

  reg_add_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (bus.a),
    .addend_i (addend),
    .mode_i   (mode_e'(bus.mode)),
    .sum_o    (res_sum),
    .flags_o  (res_flg)
  );

  always_comb begin
    acc_d = acc_q;
    ov_d  = ov_q;
    sum_d = sum_q;
    flg_d = flg_q;
    sk_vd = sk_vq;
    sk_sd = sk_sq;
    sk_fd = sk_fq;
    if (accept) acc_d = res_sum;
    if (bus.acc_clr) acc_d = '0;
    if (!ov_q || deliver) begin
      if (sk_vq) begin
        ov_d  = 1'b1;
        sum_d = sk_sq;
        flg_d = sk_fq;
        sk_vd = 1'b0;
      end else begin
        ov_d = accept;
        if (accept) begin
          sum_d = res_sum;
          flg_d = res_flg;
        end
      end
    end else if (accept) begin
      sk_vd = 1'b1;
      sk_sd = res_sum;
      sk_fd = res_flg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q <= 1'b0;
      acc_q <= '0;
      ov_q  <= 1'b0;
      sum_q <= '0;
      flg_q <= '0;
      sk_vq <= 1'b0;
      sk_sq <= '0;
      sk_fq <= '0;
    end else begin
      rdy_q <= !sk_vd;
      acc_q <= acc_d;
      ov_q  <= ov_d;
      sum_q <= sum_d;
      flg_q <= flg_d;
      sk_vq <= sk_vd;
      sk_sq <= sk_sd;
      sk_fq <= sk_fd;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = ov_q;
  assign bus.sum       = sum_q;
  assign bus.flags     = flg_q;

  generate
    if (STICKY_EN) begin : g_sticky
      flags_t stk_q, stk_d;

      always_comb begin
        stk_d = stk_q;
        if (bus.sticky_clr) stk_d = '0;
        if (deliver) stk_d = stk_d | flg_q;
      end

      always_ff @(posedge clk) begin
        if (reset) stk_q <= '0;
        else       stk_q <= stk_d;
      end

      assign bus.sticky = stk_q;
    end else begin : g_no_sticky
      assign bus.sticky = '0;
    end
  endgenerate

endmodule

// File: tb/tb_reg_add_stream.sv
// Directed bench for reg_add_stream at WIDTH=30.
module tb_reg_add_stream;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_add_stream_if #(.WIDTH(30)) bus ();

  reg_add_stream #(.WIDTH(30), .STICKY_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(string tag, logic [1:0] m, logic ac,
                    logic [29:0] av, logic [29:0] bv,
                    logic [29:0] es, logic [3:0] ef,
                    logic aclr = 1'b0, logic sclr = 1'b0);
    bus.mode      = m;
    bus.acc       = ac;
    bus.a         = av;
    bus.b         = bv;
    bus.acc_clr   = aclr;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    chk({tag, ".rdy"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    chk({tag, ".ov"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".sum"}, 64'(bus.sum), 64'(es));
    chk({tag, ".flg"}, 64'(bus.flags), 64'(ef));
    bus.sticky_clr = sclr;
    step();
    bus.sticky_clr = 1'b0;
  endtask

  logic [29:0] q[$];
  logic [29:0] nxt;
  logic [29:0] exp_s;
  int          n_acc;
  int          n_del;

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.mode       = 2'b00;
    bus.acc        = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.acc_clr    = 1'b0;
    bus.out_ready  = 1'b0;
    bus.sticky_clr = 1'b0;
    step();
    step();
    chk("rst.ov", 64'(bus.out_valid), 64'd0);
    chk("rst.sum", 64'(bus.sum), 64'd0);
    chk("rst.flg", 64'(bus.flags), 64'd0);
    chk("rst.stk", 64'(bus.sticky), 64'd0);
    chk("rst.rdy", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    step();
    chk("post.rdy", 64'(bus.in_ready), 64'd1);

    op("uwrap", 2'b00, 0, 30'h3FFFFFFF, 30'h1,
       30'h0, 4'b0101);
    op("swrap", 2'b01, 0, 30'h1FFFFFFF, 30'h1,
       30'h20000000, 4'b1010);
    op("ssat+", 2'b11, 0, 30'h1FFFFFFF, 30'h1,
       30'h1FFFFFFF, 4'b0010);
    op("usat", 2'b10, 0, 30'h3FFFFFFF, 30'h2,
       30'h3FFFFFFF, 4'b1001);
    // carry-out is reported in every mode, including here
    op("ssat-", 2'b11, 0, 30'h20000000, 30'h3FFFFFFF,
       30'h20000000, 4'b1011);
    chk("stk.all", 64'(bus.sticky), 64'hF);

    bus.sticky_clr = 1'b1;
    bus.acc_clr    = 1'b1;
    step();
    bus.sticky_clr = 1'b0;
    bus.acc_clr    = 1'b0;
    chk("stk.clr", 64'(bus.sticky), 64'd0);

    op("acc1", 2'b00, 1, 30'h5, 30'h123, 30'h5, 4'b0000);
    op("acc2", 2'b00, 1, 30'h7, 30'h123, 30'hC, 4'b0000);
    op("acc3", 2'b00, 1, 30'h3FFFFFF4, 30'h123,
       30'h0, 4'b0101);
    chk("stk.acc", 64'(bus.sticky), 64'h5);

    op("acc4", 2'b00, 1, 30'h9, 30'h0, 30'h9, 4'b0000);
    op("accclr", 2'b00, 1, 30'h1, 30'h0, 30'hA, 4'b0000,
       1'b1);
    op("acc5", 2'b00, 1, 30'h3, 30'h0, 30'h3, 4'b0000);
    op("stkdel", 2'b01, 0, 30'h1FFFFFFF, 30'h1,
       30'h20000000, 4'b1010, 1'b0, 1'b1);
    chk("stk.deliv", 64'(bus.sticky), 64'hA);

    bus.mode = 2'b00;
    bus.acc  = 1'b0;
    bus.b    = 30'h1;
    nxt      = 30'h100;
    n_acc    = 0;
    n_del    = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.out_ready = (cyc >= 4);
      bus.in_valid  = (cyc < 8);
      bus.a         = nxt;
      if (cyc == 2 || cyc == 3)
        chk("bp.rdy", 64'(bus.in_ready), 64'd0);
      if (cyc >= 1 && cyc <= 3)
        chk("bp.hold", 64'(bus.sum), 64'h101);
      if (q.size() != 0)
        chk("bp.gap", 64'(bus.out_valid), 64'd1);
      if (bus.out_valid && bus.out_ready) begin
        exp_s = (q.size() != 0) ? q.pop_front() : '1;
        chk("bp.order", 64'(bus.sum), 64'(exp_s));
        n_del++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(nxt + 30'h1);
        nxt = nxt + 30'h1;
        n_acc++;
        if (cyc < 4) chk("bp.early", 64'(n_acc), 64'(cyc + 1));
      end
      step();
    end
    chk("bp.nacc", 64'(n_acc), 64'd5);
    chk("bp.ndel", 64'(n_del), 64'd5);
    chk("bp.ov", 64'(bus.out_valid), 64'd0);

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 30'h40;
    step();
    step();
    bus.in_valid = 1'b0;
    chk("full.rdy", 64'(bus.in_ready), 64'd0);
    chk("full.ov", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr.ov", 64'(bus.out_valid), 64'd0);
    chk("mr.sum", 64'(bus.sum), 64'd0);
    chk("mr.stk", 64'(bus.sticky), 64'd0);
    chk("mr.rdy", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step();
    chk("mr.rdy1", 64'(bus.in_ready), 64'd1);
    chk("mr.ov1", 64'(bus.out_valid), 64'd0);
    op("mr.acc", 2'b00, 1, 30'h4, 30'h77, 30'h4, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
